// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bus: BRAM read port on one side, decode handshake on the other.
// The sequencer takes the master view; memory/decode (or a bench) take the slave view.
interface fetch_sequencer_if;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   modport master (
      output mem_en,
      output mem_addr,
      input  mem_rdata,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  mem_en,
      input  mem_addr,
      output mem_rdata,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch controller for a one-cycle-latency instruction BRAM: owns the pc, issues reads,
// parks the in-flight word in a one-entry skid buffer on decode stalls, squashes on redirect.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               busy,
   fetch_sequencer_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic        inflight_reg, inflight_next;
   logic [31:0] inflight_pc_reg, inflight_pc_next;
   logic        skid_valid_reg, skid_valid_next;
   logic [31:0] skid_data_reg, skid_data_next;
   logic [31:0] skid_pc_reg, skid_pc_next;

   logic        out_valid;
   logic        issue;
   logic        instr_valid_int;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         pc_reg          <= RESET_PC;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= 32'd0;
         skid_valid_reg  <= 1'b0;
         skid_data_reg   <= 32'd0;
         skid_pc_reg     <= 32'd0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         inflight_reg    <= inflight_next;
         inflight_pc_reg <= inflight_pc_next;
         skid_valid_reg  <= skid_valid_next;
         skid_data_reg   <= skid_data_next;
         skid_pc_reg     <= skid_pc_next;
      end
   end

   // Control FSM; redirect never changes state, so redirect+pause in RUN still lands in PAUSED.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)  state_next = RUN;
         RUN:     if (pause)  state_next = PAUSED;
         PAUSED:  if (!pause) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // A word is presented whenever one is parked or arriving from the BRAM this cycle.
   assign out_valid = skid_valid_reg | inflight_reg;
   assign issue     = (state_reg == RUN) & ~pause & ~redirect
                    & (~out_valid | bus.instr_ready);

   always_comb begin
      pc_next          = pc_reg;
      inflight_next    = issue;
      inflight_pc_next = inflight_pc_reg;
      skid_valid_next  = skid_valid_reg;
      skid_data_next   = skid_data_reg;
      skid_pc_next     = skid_pc_reg;

      if (issue) begin
         pc_next          = pc_reg + 32'd1;
         inflight_pc_next = pc_reg;
      end

      if (redirect) begin
         pc_next         = redirect_pc;
         inflight_next   = 1'b0;
         skid_valid_next = 1'b0;
      end else if (inflight_reg && !bus.instr_ready) begin
         // BRAM data is only valid for one cycle, so a stalled arrival must be parked now.
         skid_valid_next = 1'b1;
         skid_data_next  = bus.mem_rdata;
         skid_pc_next    = inflight_pc_reg;
      end else if (skid_valid_reg && bus.instr_ready) begin
         skid_valid_next = 1'b0;
      end
   end

   assign instr_valid_int = out_valid & ~redirect;

   always_comb begin
      bus.instr    = 32'd0;
      bus.instr_pc = 32'd0;
      if (instr_valid_int) begin
         if (skid_valid_reg) begin
            bus.instr    = skid_data_reg;
            bus.instr_pc = skid_pc_reg;
         end else begin
            bus.instr    = bus.mem_rdata;
            bus.instr_pc = inflight_pc_reg;
         end
      end
   end

   assign bus.instr_valid = instr_valid_int;
   assign bus.mem_en      = issue;
   assign bus.mem_addr    = pc_reg;
   assign busy            = (state_reg != IDLE) | inflight_reg | skid_valid_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: BRAM model returns 32'hA000_0000 + address one cycle
// after each read; each scenario task drives inputs and checks outputs inline.
module tb_fetch_sequencer;
   logic        clk;
   logic        rst;
   logic        start;
   logic        pause;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        busy;
   int          checks;
   int          errors;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pause       (pause),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .busy        (busy),
      .bus         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_en) bus.mem_rdata <= 32'hA000_0000 + bus.mem_addr;
   end

   always @(negedge clk) begin
      if (bus.instr_valid && bus.instr_ready)
         $display("xfer pc=%h instr=%h", bus.instr_pc, bus.instr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Reset, then pulse start; returns in cycle 1 (first read issuing) before settling.
   task automatic restart();
      rst = 1'b1; start = 1'b0; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      bus.instr_ready = 1'b1;
      tick();
      rst = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      bus.instr_ready = 1'b1;
      tick(); tick();
      settle();
      if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
      checks++;
      if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
      checks++;
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
      checks++;
      if (bus.instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instr); end
      checks++;
      if (bus.instr_pc !== 32'd0) begin errors++; $display("FAIL reset_instr_pc got %h want 0", bus.instr_pc); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      rst = 1'b0;
   endtask

   task automatic test_idle_redirect();
      tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      settle();
      if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL idle_redir_mem_en got %b want 0", bus.mem_en); end
      checks++;
      tick();
      redirect = 1'b0;
      settle();
      if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL idle_redir_addr got %h want 100", bus.mem_addr); end
      checks++;
      if (busy !== 1'b0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL idle_redir_quiet got busy=%b mem_en=%b want 0/0", busy, bus.mem_en); end
      checks++;
      start = 1'b1;
      tick();
      start = 1'b0;
      settle();
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL idle_redir_issue got en=%b addr=%h want 1/100", bus.mem_en, bus.mem_addr); end
      checks++;
      tick(); settle();
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== 32'hA000_0100) begin
         errors++; $display("FAIL idle_redir_data got v=%b pc=%h instr=%h want 1/100/a0000100", bus.instr_valid, bus.instr_pc, bus.instr);
      end
      checks++;
   endtask

   task automatic test_basic_stream();
      restart();
      settle();
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'd0 || bus.instr_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL stream_first_issue got en=%b addr=%h v=%b busy=%b want 1/0/0/1", bus.mem_en, bus.mem_addr, bus.instr_valid, busy);
      end
      checks++;
      for (int i = 0; i < 6; i++) begin
         tick(); settle();
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(i) || bus.instr !== 32'hA000_0000 + 32'(i)) begin
            errors++; $display("FAIL stream_data[%0d] got v=%b pc=%h instr=%h want 1/%h/%h", i, bus.instr_valid, bus.instr_pc, bus.instr, 32'(i), 32'hA000_0000 + 32'(i));
         end
         checks++;
         if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'(i + 1)) begin
            errors++; $display("FAIL stream_issue[%0d] got en=%b addr=%h want 1/%h", i, bus.mem_en, bus.mem_addr, 32'(i + 1));
         end
         checks++;
      end
   endtask

   task automatic test_backpressure();
      restart();
      settle();
      for (int i = 0; i < 5; i++) begin
         tick(); settle();
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         bus.instr_ready = 1'b0;
         settle();
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'd5 || bus.instr !== 32'hA000_0005) begin
            errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h instr=%h want 1/5/a0000005", c, bus.instr_valid, bus.instr_pc, bus.instr);
         end
         checks++;
         if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL stall_no_issue[%0d] got %b want 0", c, bus.mem_en); end
         checks++;
      end
      tick();
      bus.instr_ready = 1'b1;
      settle();
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'd5 || bus.mem_en !== 1'b1 || bus.mem_addr !== 32'd6) begin
         errors++; $display("FAIL stall_release got v=%b pc=%h en=%b addr=%h want 1/5/1/6", bus.instr_valid, bus.instr_pc, bus.mem_en, bus.mem_addr);
      end
      checks++;
      for (int i = 6; i < 8; i++) begin
         tick(); settle();
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(i) || bus.instr !== 32'hA000_0000 + 32'(i)) begin
            errors++; $display("FAIL stall_after[%0d] got v=%b pc=%h instr=%h", i, bus.instr_valid, bus.instr_pc, bus.instr);
         end
         checks++;
      end
   endtask

   task automatic test_redirect_squash();
      restart();
      settle();
      for (int i = 0; i < 9; i++) begin
         tick(); settle();
      end
      tick();
      bus.instr_ready = 1'b0;
      settle();
      if (bus.instr_pc !== 32'd9 || bus.mem_en !== 1'b0) begin
         errors++; $display("FAIL squash_pre got pc=%h en=%b want 9/0", bus.instr_pc, bus.mem_en);
      end
      checks++;
      tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      settle();
      if (bus.instr_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.instr !== 32'd0 || bus.instr_pc !== 32'd0) begin
         errors++; $display("FAIL squash_cycle got v=%b en=%b instr=%h pc=%h want 0/0/0/0", bus.instr_valid, bus.mem_en, bus.instr, bus.instr_pc);
      end
      checks++;
      tick();
      redirect = 1'b0; bus.instr_ready = 1'b1;
      settle();
      if (bus.instr_valid !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h40) begin
         errors++; $display("FAIL squash_issue got v=%b en=%b addr=%h want 0/1/40", bus.instr_valid, bus.mem_en, bus.mem_addr);
      end
      checks++;
      for (int i = 0; i < 2; i++) begin
         tick(); settle();
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 + 32'(i) || bus.instr !== 32'hA000_0040 + 32'(i)) begin
            errors++; $display("FAIL squash_target[%0d] got v=%b pc=%h instr=%h", i, bus.instr_valid, bus.instr_pc, bus.instr);
         end
         checks++;
      end
   endtask

   task automatic test_pause();
      restart();
      settle();
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
      end
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'd3) begin
         errors++; $display("FAIL pause_pre got en=%b addr=%h want 1/3", bus.mem_en, bus.mem_addr);
      end
      checks++;
      tick();
      pause = 1'b1;
      settle();
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'd3 || bus.mem_en !== 1'b0) begin
         errors++; $display("FAIL pause_drain got v=%b pc=%h en=%b want 1/3/0", bus.instr_valid, bus.instr_pc, bus.mem_en);
      end
      checks++;
      tick(); settle();
      if (bus.instr_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
         errors++; $display("FAIL pause_idle got v=%b en=%b want 0/0", bus.instr_valid, bus.mem_en);
      end
      checks++;
      tick();
      pause = 1'b0;
      settle();
      if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL pause_release_delay got en=%b want 0", bus.mem_en); end
      checks++;
      tick(); settle();
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'd4) begin
         errors++; $display("FAIL pause_resume got en=%b addr=%h want 1/4", bus.mem_en, bus.mem_addr);
      end
      checks++;
      tick(); settle();
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'd4 || bus.instr !== 32'hA000_0004) begin
         errors++; $display("FAIL pause_resume_data got v=%b pc=%h instr=%h want 1/4/a0000004", bus.instr_valid, bus.instr_pc, bus.instr);
      end
      checks++;
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFFE; exp_pc[1] = 32'hFFFF_FFFF; exp_pc[2] = 32'h0000_0000;
      restart();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      settle();
      if (bus.mem_en !== 1'b0 || bus.instr_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_redirect got en=%b v=%b want 0/0", bus.mem_en, bus.instr_valid);
      end
      checks++;
      tick();
      redirect = 1'b0;
      settle();
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL wrap_issue got en=%b addr=%h want 1/fffffffe", bus.mem_en, bus.mem_addr);
      end
      checks++;
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc[i] || bus.instr !== 32'hA000_0000 + exp_pc[i]) begin
            errors++; $display("FAIL wrap_seq[%0d] got v=%b pc=%h instr=%h want pc %h", i, bus.instr_valid, bus.instr_pc, bus.instr, exp_pc[i]);
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid_run();
      restart();
      settle();
      tick();
      bus.instr_ready = 1'b0;
      settle();
      tick(); settle();
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL midrst_pre got v=%b pc=%h busy=%b want 1/0/1", bus.instr_valid, bus.instr_pc, busy);
      end
      checks++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      if (bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 || bus.instr_pc !== 32'd0 || busy !== 1'b0
          || bus.mem_en !== 1'b0 || bus.mem_addr !== 32'd0) begin
         errors++; $display("FAIL midrst_state got v=%b instr=%h pc=%h busy=%b en=%b addr=%h want all 0",
                            bus.instr_valid, bus.instr, bus.instr_pc, busy, bus.mem_en, bus.mem_addr);
      end
      checks++;
      bus.instr_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      settle();
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'd0) begin
         errors++; $display("FAIL midrst_restart got en=%b addr=%h want 1/0", bus.mem_en, bus.mem_addr);
      end
      checks++;
      tick(); settle();
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'd0 || bus.instr !== 32'hA000_0000) begin
         errors++; $display("FAIL midrst_data got v=%b pc=%h instr=%h want 1/0/a0000000", bus.instr_valid, bus.instr_pc, bus.instr);
      end
      checks++;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_idle_redirect();
      test_basic_stream();
      test_backpressure();
      test_redirect_squash();
      test_pause();
      test_wrap();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
